// File: rtl/fir_frame_pkg.sv
// fir_frame_pkg: frame/sample types and stream FSM states shared by the FIR lowpass stage and its frame streamer
package fir_frame_pkg;
  localparam int FRAME_LEN = 256;
  localparam int DATA_W = 8;
  typedef logic [DATA_W-1:0] sample_t;
  typedef sample_t [0:FRAME_LEN-1] frame_t;
  typedef enum logic {IDLE, STREAM} stream_state_t;
endpackage

// File: rtl/fir_frame_streamer.sv
// fir_frame_streamer: snapshots a filter output frame on the rdy_flg rising edge and streams it one sample per valid/ready transfer
//   clk, rst (async, active-low)       clock and reset
//   rdy_flg, frameIn                   filter frame-ready level and parallel frame
//   sampleOut/Valid/Ready/Last         downstream stream interface
//   busy, frame_done                   streaming in progress, pulse after the last transfer
//   overrun_flg, clr_overrun           sticky dropped-frame flag and its synchronous clear
module fir_frame_streamer
  import fir_frame_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    rdy_flg,
  input  frame_t  frameIn,
  output sample_t sampleOut,
  output logic    sampleValid,
  input  logic    sampleReady,
  output logic    sampleLast,
  output logic    busy,
  output logic    frame_done,
  output logic    overrun_flg,
  input  logic    clr_overrun
);
  localparam int CNT_W = $clog2(FRAME_LEN);
  stream_state_t state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d, idx_inc;
  sample_t out_q, out_d;
  logic valid_q, valid_d, last_q, last_d, busy_q, busy_d, done_q, done_d, ovr_q, ovr_d;
  logic rdy_q, new_frame, xfer, at_last, cap;
  frame_t frame_q;
  assign new_frame = rdy_flg & ~rdy_q;
  assign xfer = valid_q & sampleReady;
  assign at_last = idx_q == CNT_W'(FRAME_LEN-1);
  assign idx_inc = idx_q + CNT_W'(1);
  // Outputs are registered, so the next sample is looked up one index ahead.
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    out_d = out_q;
    valid_d = valid_q;
    last_d = last_q;
    busy_d = busy_q;
    done_d = 1'b0;
    ovr_d = ovr_q & ~clr_overrun;
    cap = 1'b0;
    if (state_q == IDLE) begin
      if (new_frame) begin
        cap = 1'b1;
        state_d = STREAM;
        idx_d = '0;
        out_d = frameIn[0];
        valid_d = 1'b1;
        last_d = 1'b0;
        busy_d = 1'b1;
      end
    end else if (xfer && at_last) begin
      done_d = 1'b1;
      idx_d = '0;
      last_d = 1'b0;
      cap = new_frame;
      state_d = new_frame ? STREAM : IDLE;
      out_d = new_frame ? frameIn[0] : '0;
      valid_d = new_frame;
      busy_d = new_frame;
    end else begin
      ovr_d = ovr_d | new_frame;
      if (xfer) begin
        idx_d = idx_inc;
        out_d = frame_q[idx_inc];
        last_d = idx_q == CNT_W'(FRAME_LEN-2);
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      out_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovr_q <= 1'b0;
      rdy_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      out_q <= out_d;
      valid_q <= valid_d;
      last_q <= last_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ovr_q <= ovr_d;
      rdy_q <= rdy_flg;
    end
  end
  always_ff @(posedge clk) if (cap) frame_q <= frameIn;
  assign sampleOut = out_q;
  assign sampleValid = valid_q;
  assign sampleLast = last_q;
  assign busy = busy_q;
  assign frame_done = done_q;
  assign overrun_flg = ovr_q;
endmodule

// File: tb/tb_fir_frame_streamer.sv
// tb_fir_frame_streamer: directed self-checking bench for fir_frame_streamer
module tb_fir_frame_streamer;
  import fir_frame_pkg::*;
  logic clk = 1'b0, rst = 1'b0, rdy_flg = 1'b0, sampleReady = 1'b0, clr_overrun = 1'b0;
  frame_t frameIn = '0;
  sample_t sampleOut;
  logic sampleValid, sampleLast, busy, frame_done, overrun_flg;
  int vec = 0, errs = 0;
  fir_frame_streamer dut (
    .clk(clk), .rst(rst), .rdy_flg(rdy_flg), .frameIn(frameIn),
    .sampleOut(sampleOut), .sampleValid(sampleValid), .sampleReady(sampleReady),
    .sampleLast(sampleLast), .busy(busy), .frame_done(frame_done),
    .overrun_flg(overrun_flg), .clr_overrun(clr_overrun)
  );
  always #5 clk = ~clk;
  function automatic sample_t pat(int kind, int i);
    case (kind)
      0: return 8'(i);
      1: return 8'(255 - i);
      2: return 8'(i) ^ 8'h3C;
      3: return 8'(i * 3);
      4: return 8'hAA;
      5: return 8'h55;
      default: return ~8'(i * 3);
    endcase
  endfunction
  task automatic load(input int kind);
    for (int i = 0; i < FRAME_LEN; i++) frameIn[i] = pat(kind, i);
  endtask
  function automatic logic [12:0] obs();
    return {sampleValid, busy, frame_done, sampleLast, overrun_flg, sampleOut};
  endfunction
  function automatic logic [12:0] ex(bit v, bit b, bit d, bit l, bit o, sample_t s);
    return {v, b, d, l, o, s};
  endfunction
  task automatic test_reset;
    logic [12:0] e;
    @(negedge clk);
    e = ex(0, 0, 0, 0, 0, 8'h00);
    vec++; if (obs() !== e) begin errs++; $display("FAIL reset got %h exp %h", obs(), e); end
    rst = 1'b1;
    @(negedge clk);
    vec++; if (obs() !== e) begin errs++; $display("FAIL reset_idle got %h exp %h", obs(), e); end
  endtask
  task automatic test_ramp;
    logic [12:0] e;
    @(negedge clk);
    load(0); rdy_flg = 1'b1; sampleReady = 1'b1;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (k == 0) rdy_flg = 1'b0;
      e = ex(1, 1, 0, k == 255, 0, pat(0, k));
      vec++; if (obs() !== e) begin errs++; $display("FAIL ramp k=%0d got %h exp %h", k, obs(), e); end
    end
    @(negedge clk);
    e = ex(0, 0, 1, 0, 0, 8'h00);
    vec++; if (obs() !== e) begin errs++; $display("FAIL ramp_done got %h exp %h", obs(), e); end
    @(negedge clk);
    e = ex(0, 0, 0, 0, 0, 8'h00);
    vec++; if (obs() !== e) begin errs++; $display("FAIL ramp_idle got %h exp %h", obs(), e); end
  endtask
  task automatic test_backpressure;
    logic [12:0] e;
    int k = 0, c = 0;
    @(negedge clk);
    load(1); rdy_flg = 1'b1; sampleReady = 1'b0;
    while (k < 256 && c < 1500) begin
      @(negedge clk);
      rdy_flg = 1'b0; c++;
      e = ex(1, 1, 0, k == 255, 0, pat(1, k));
      vec++; if (obs() !== e) begin errs++; $display("FAIL bp c=%0d k=%0d got %h exp %h", c, k, obs(), e); end
      sampleReady = (c % 3 == 1) || (c % 7 == 0);
      if (sampleReady) k++;
    end
    vec++; if (k != 256) begin errs++; $display("FAIL bp_timeout got %0d exp 256", k); end
    @(negedge clk);
    sampleReady = 1'b1;
    e = ex(0, 0, 1, 0, 0, 8'h00);
    vec++; if (obs() !== e) begin errs++; $display("FAIL bp_done got %h exp %h", obs(), e); end
  endtask
  task automatic test_overrun;
    logic [12:0] e;
    @(negedge clk);
    load(2); rdy_flg = 1'b1; sampleReady = 1'b1;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (k == 0) begin rdy_flg = 1'b0; load(4); end
      e = ex(1, 1, 0, k == 255, (k > 100 && k <= 150) || k > 200, pat(2, k));
      vec++; if (obs() !== e) begin errs++; $display("FAIL ovr k=%0d got %h exp %h", k, obs(), e); end
      if (k == 100) rdy_flg = 1'b1;
      if (k == 101) rdy_flg = 1'b0;
      if (k == 150) clr_overrun = 1'b1;
      if (k == 151) clr_overrun = 1'b0;
      if (k == 200) begin rdy_flg = 1'b1; clr_overrun = 1'b1; end
      if (k == 201) begin rdy_flg = 1'b0; clr_overrun = 1'b0; end
    end
    @(negedge clk);
    e = ex(0, 0, 1, 0, 1, 8'h00);
    vec++; if (obs() !== e) begin errs++; $display("FAIL ovr_done got %h exp %h", obs(), e); end
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    e = ex(0, 0, 0, 0, 0, 8'h00);
    vec++; if (obs() !== e) begin errs++; $display("FAIL ovr_clear got %h exp %h", obs(), e); end
  endtask
  task automatic test_back_to_back;
    logic [12:0] e;
    @(negedge clk);
    load(0); rdy_flg = 1'b1; sampleReady = 1'b1;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (k == 0) rdy_flg = 1'b0;
      e = ex(1, 1, 0, k == 255, 0, pat(0, k));
      vec++; if (obs() !== e) begin errs++; $display("FAIL b2b_a k=%0d got %h exp %h", k, obs(), e); end
      if (k == 255) begin load(5); rdy_flg = 1'b1; end
    end
    @(negedge clk);
    rdy_flg = 1'b0;
    e = ex(1, 1, 1, 0, 0, 8'h55);
    vec++; if (obs() !== e) begin errs++; $display("FAIL b2b_join got %h exp %h", obs(), e); end
    for (int k = 1; k < 256; k++) begin
      @(negedge clk);
      e = ex(1, 1, 0, k == 255, 0, 8'h55);
      vec++; if (obs() !== e) begin errs++; $display("FAIL b2b_b k=%0d got %h exp %h", k, obs(), e); end
    end
    @(negedge clk);
    e = ex(0, 0, 1, 0, 0, 8'h00);
    vec++; if (obs() !== e) begin errs++; $display("FAIL b2b_done got %h exp %h", obs(), e); end
  endtask
  task automatic test_midreset;
    logic [12:0] e;
    @(negedge clk);
    load(3); rdy_flg = 1'b1; sampleReady = 1'b1;
    for (int k = 0; k <= 37; k++) begin
      @(negedge clk);
      e = ex(1, 1, 0, 0, 0, pat(3, k));
      vec++; if (obs() !== e) begin errs++; $display("FAIL mr_pre k=%0d got %h exp %h", k, obs(), e); end
    end
    #2 rst = 1'b0;
    #1 e = ex(0, 0, 0, 0, 0, 8'h00);
    vec++; if (obs() !== e) begin errs++; $display("FAIL mr_async got %h exp %h", obs(), e); end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vec++; if (obs() !== e) begin errs++; $display("FAIL mr_held k=%0d got %h exp %h", k, obs(), e); end
    end
    rdy_flg = 1'b0;
    @(negedge clk);
    rdy_flg = 1'b1;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (k == 0) rdy_flg = 1'b0;
      e = ex(1, 1, 0, k == 255, 0, pat(3, k));
      vec++; if (obs() !== e) begin errs++; $display("FAIL mr_post k=%0d got %h exp %h", k, obs(), e); end
    end
    @(negedge clk);
    e = ex(0, 0, 1, 0, 0, 8'h00);
    vec++; if (obs() !== e) begin errs++; $display("FAIL mr_done got %h exp %h", obs(), e); end
  endtask
  task automatic test_capture;
    logic [12:0] e;
    @(negedge clk);
    load(6); rdy_flg = 1'b1; sampleReady = 1'b1;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (k == 0) begin rdy_flg = 1'b0; load(3); end
      e = ex(1, 1, 0, k == 255, 0, pat(6, k));
      vec++; if (obs() !== e) begin errs++; $display("FAIL cap k=%0d got %h exp %h", k, obs(), e); end
    end
    @(negedge clk);
    e = ex(0, 0, 1, 0, 0, 8'h00);
    vec++; if (obs() !== e) begin errs++; $display("FAIL cap_done got %h exp %h", obs(), e); end
  endtask
  initial begin
    test_reset;
    test_ramp;
    test_backpressure;
    test_overrun;
    test_back_to_back;
    test_midreset;
    test_capture;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
